usb_reg_arbiter: RTL and testbench
==================================

# usb_reg_arbiter

Shares the FPGA register bus (6-bit address, byte count, 8-bit data, read/write strobes, address-valid) between the USB host interface and one internal local master, such as a trigger sequencer or self-test engine. It sits between the USB register front-end and the register slaves. The host always has absolute priority and is never stalled. The local master gets the bus only after a configurable host-idle gap, runs single or burst transactions, and is aborted the instant the host becomes active.

## Interface
- pBYTECNT_SIZE, 7: width of byte count and burst length
- pIDLE_GAP, 4: consecutive host-idle cycles required before a local grant (1..15)
- cwusb_clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- host_address / host_bytecnt / host_datao  in  6 / pBYTECNT_SIZE / 8  host bus fields
- host_read / host_write / host_addrvalid  in  1 each  host strobes
- host_datai  out  8  read data to host (= reg_datai, always)
- lcl_req  in  1  level request; held until lcl_done or lcl_abort
- lcl_wr  in  1  1 = write, 0 = read
- lcl_address  in  6  target register
- lcl_len  in  pBYTECNT_SIZE  byte count; 0 is treated as 1
- lcl_wdata  in  8  current write byte
- lcl_wready  out  1  pulse: lcl_wdata consumed this cycle
- lcl_rdata  out  8  captured read byte
- lcl_rvalid  out  1  pulse: lcl_rdata valid
- lcl_done / lcl_abort  out  1 each  one-cycle completion / preemption pulses
- lcl_busy  out  1  local transaction in progress
- reg_address / reg_bytecnt / reg_datao  out  6 / pBYTECNT_SIZE / 8  to slaves
- reg_read / reg_write / reg_addrvalid  out  1 each  to slaves
- reg_datai  in  8  slave read data

## Operation
- Host activity is host_addrvalid | host_read | host_write.
- Idle counter: clears on host activity, otherwise increments, saturating at pIDLE_GAP.
- Owner select is combinational. The host owns the bus unless the FSM is in ADDR, XFER or WAIT and there is no host activity in the same cycle. When the host owns it, reg_* equals host_* exactly (zero-latency pass-through).
- FSM states:
  - IDLE → ADDR when lcl_req=1 and the idle counter equals pIDLE_GAP. On that edge, latch lcl_wr, lcl_address and the effective length.
  - ADDR: reg_addrvalid=1, reg_address=latched address, reg_bytecnt=0, no strobes. Next state XFER.
  - XFER: reg_addrvalid=1.
    - Write: reg_write=1, reg_datao=lcl_wdata, lcl_wready=1.
    - Read: reg_read=1.
    - Next state WAIT.
  - WAIT: reg_addrvalid=1, no strobes.
    - Read: reg_datai is registered into lcl_rdata, and lcl_rvalid pulses the next cycle.
    - The byte counter increments at the end of WAIT.
    - Next state XFER if bytes remain, else DONE.
  - DONE: reg_addrvalid=0, lcl_done=1. Next state IDLE.
- Preemption: host activity in ADDR, XFER or WAIT hands the bus to the host that cycle with no local strobe emitted. The FSM goes to IDLE, and lcl_abort pulses the next cycle. A partially completed burst is not resumed; the master re-requests.
- Host activity in IDLE with lcl_req high simply delays the grant.
- reg_addrvalid is low for at least one cycle between consecutive local transactions, because DONE and IDLE both hold it low.
- Byte count never wraps within a local burst (maximum 2^pBYTECNT_SIZE−1 bytes).

## Timing
- Reset values:
  - FSM in IDLE, idle counter 0, latched fields 0.
  - lcl_wready, lcl_rvalid, lcl_done, lcl_abort, lcl_busy are all 0; lcl_rdata is 0.
  - reg_* follow host_*.
- Grant latency: 1 cycle after the sampling edge, when the idle gap is already met.
- Single write: ADDR, XFER, WAIT, DONE is 4 cycles from grant to lcl_done.
- N-byte burst: 2 + 2N cycles.
- Read data: slaves must present reg_datai in the cycle after reg_read (the WAIT cycle).
- lcl_busy is high in ADDR, XFER, WAIT and DONE.
- Reset asserted mid-transaction: all local outputs drop immediately and no strobe is issued.

## Configuration
- REG_ARB_BURST_EN defined: lcl_len is honoured and reg_bytecnt steps 0..len−1.
- REG_ARB_BURST_EN undefined: lcl_len is ignored, every local transaction is one byte, and reg_bytecnt is always 0 for local accesses. Ports are unchanged.

## Structure
- Package usb_reg_arb_pkg holds:
  - FSM state encoding (IDLE, ADDR, XFER, WAIT, DONE);
  - owner constants (OWNER_HOST, OWNER_LCL);
  - the idle-counter width constant.
- Sub-module usb_reg_arb_idle_mon: saturating host-idle counter with a gap_met output.

## Test plan
- Reset, then toggle host_* → reg_* mirrors host_* in the same cycle; all lcl_* outputs are 0.
- Host idle ≥4 cycles, lcl_req with write to 0x12, data 0xA5 → reg_write for one cycle with reg_address=0x12 and reg_datao=0xA5; lcl_done 4 cycles after grant.
- Local read of 0x05, len 3 (BURST_EN), slave returns 0x10+bytecnt → lcl_rvalid three times with rdata 0x10, 0x11, 0x12; lcl_done at 8 cycles.
- host_addrvalid rises in the XFER cycle of a local write → no reg_write from local, bus passes to host same cycle, lcl_abort pulses next cycle.
- lcl_req held while host is active every 3rd cycle (gap 4) → no grant until a 4-cycle idle run, then grant.
- BURST_EN undefined, lcl_len=5 → exactly one access, reg_bytecnt=0.

Source files
------------

// File: rtl/usb_reg_arb_pkg.sv
// usb_reg_arb_pkg: shared FSM encoding, bus-owner codes and idle-counter width for usb_reg_arbiter
package usb_reg_arb_pkg;
  localparam int IDLE_CW = 4;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_XFER = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic OWNER_HOST = 1'b0;
  localparam logic OWNER_LCL = 1'b1;
endpackage

// File: rtl/usb_reg_arb_idle_mon.sv
// usb_reg_arb_idle_mon: saturating host-idle counter; ports clk_i, rst_ni (async low), host_act_i, gap_met_o (count reached pIDLE_GAP)
module usb_reg_arb_idle_mon
  import usb_reg_arb_pkg::*;
#(
  parameter int pIDLE_GAP = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic host_act_i,
  output logic gap_met_o
);
  localparam logic [IDLE_CW-1:0] GAP = IDLE_CW'(pIDLE_GAP);
  logic [IDLE_CW-1:0] cnt_q, cnt_d;
  assign gap_met_o = cnt_q == GAP;
  assign cnt_d = host_act_i ? '0 : gap_met_o ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/usb_reg_arbiter.sv
// usb_reg_arbiter: shares the register bus between the USB host (absolute priority, zero-latency pass-through) and one local master; host_* in, reg_* out to slaves, lcl_* local handshake; macro REG_ARB_BURST_EN enables multi-byte local bursts
module usb_reg_arbiter
  import usb_reg_arb_pkg::*;
#(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pIDLE_GAP = 4
) (
  input  logic                     cwusb_clk,
  input  logic                     reset_n,
  input  logic [5:0]               host_address,
  input  logic [pBYTECNT_SIZE-1:0] host_bytecnt,
  input  logic [7:0]               host_datao,
  input  logic                     host_read,
  input  logic                     host_write,
  input  logic                     host_addrvalid,
  output logic [7:0]               host_datai,
  input  logic                     lcl_req,
  input  logic                     lcl_wr,
  input  logic [5:0]               lcl_address,
  input  logic [pBYTECNT_SIZE-1:0] lcl_len,
  input  logic [7:0]               lcl_wdata,
  output logic                     lcl_wready,
  output logic [7:0]               lcl_rdata,
  output logic                     lcl_rvalid,
  output logic                     lcl_done,
  output logic                     lcl_abort,
  output logic                     lcl_busy,
  output logic [5:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               reg_datao,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     reg_addrvalid,
  input  logic [7:0]               reg_datai
);
  logic [2:0] state_q, state_d;
  logic wr_q;
  logic [5:0] addr_q;
  logic [pBYTECNT_SIZE-1:0] len_q, cnt_q, cnt_d, eff_len;
  logic [7:0] rdata_q;
  logic rvalid_q, abort_q;
  logic host_act, gap_met, lcl_phase, owner, grant, in_xfer, in_wait;
  assign host_act = host_addrvalid | host_read | host_write;
  assign lcl_phase = state_q == ST_ADDR || state_q == ST_XFER || state_q == ST_WAIT;
  assign owner = (lcl_phase && !host_act) ? OWNER_LCL : OWNER_HOST;
  assign in_xfer = owner == OWNER_LCL && state_q == ST_XFER;
  assign in_wait = owner == OWNER_LCL && state_q == ST_WAIT;
  assign grant = state_q == ST_IDLE && lcl_req && gap_met && !host_act;
`ifdef REG_ARB_BURST_EN
  assign eff_len = (lcl_len == '0) ? pBYTECNT_SIZE'(1) : lcl_len;
`else
  // Single-byte build: the length port is present but deliberately has no effect.
  assign eff_len = pBYTECNT_SIZE'(1) | (lcl_len & '0);
`endif
  usb_reg_arb_idle_mon #(.pIDLE_GAP(pIDLE_GAP)) u_idle_mon (
    .clk_i(cwusb_clk),
    .rst_ni(reset_n),
    .host_act_i(host_act),
    .gap_met_o(gap_met)
  );
  assign host_datai = reg_datai;
  assign reg_address = owner == OWNER_LCL ? addr_q : host_address;
  assign reg_bytecnt = owner == OWNER_LCL ? (state_q == ST_ADDR ? '0 : cnt_q) : host_bytecnt;
  assign reg_datao = owner == OWNER_LCL ? lcl_wdata : host_datao;
  assign reg_read = owner == OWNER_LCL ? in_xfer && !wr_q : host_read;
  assign reg_write = owner == OWNER_LCL ? in_xfer && wr_q : host_write;
  assign reg_addrvalid = owner == OWNER_LCL ? 1'b1 : host_addrvalid;
  assign lcl_wready = in_xfer && wr_q;
  assign lcl_rdata = rdata_q;
  assign lcl_rvalid = rvalid_q;
  assign lcl_done = state_q == ST_DONE;
  assign lcl_abort = abort_q;
  assign lcl_busy = state_q != ST_IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: if (grant) begin
        state_d = ST_ADDR;
        cnt_d = '0;
      end
      ST_ADDR: state_d = ST_XFER;
      ST_XFER: state_d = ST_WAIT;
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == len_q - 1'b1) ? ST_DONE : ST_XFER;
      end
      default: state_d = ST_IDLE;
    endcase
    // Host activity during a local phase wins immediately; the burst is dropped, not resumed.
    if (lcl_phase && host_act) state_d = ST_IDLE;
  end
  always_ff @(posedge cwusb_clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      len_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (grant) begin
        wr_q <= lcl_wr;
        addr_q <= lcl_address;
        len_q <= eff_len;
      end
      if (in_wait && !wr_q) rdata_q <= reg_datai;
      rvalid_q <= in_wait && !wr_q;
      abort_q <= lcl_phase && host_act;
    end
endmodule

// File: tb/tb_usb_reg_arbiter.sv
// tb_usb_reg_arbiter: directed self-checking bench for usb_reg_arbiter
module tb_usb_reg_arbiter;
  logic cwusb_clk = 1'b0;
  logic reset_n = 1'b1;
  logic [5:0] host_address = '0;
  logic [6:0] host_bytecnt = '0;
  logic [7:0] host_datao = '0;
  logic host_read = 1'b0, host_write = 1'b0, host_addrvalid = 1'b0;
  logic [7:0] host_datai;
  logic lcl_req = 1'b0, lcl_wr = 1'b0;
  logic [5:0] lcl_address = '0;
  logic [6:0] lcl_len = '0;
  logic [7:0] lcl_wdata = '0;
  logic lcl_wready, lcl_rvalid, lcl_done, lcl_abort, lcl_busy;
  logic [7:0] lcl_rdata;
  logic [5:0] reg_address;
  logic [6:0] reg_bytecnt;
  logic [7:0] reg_datao;
  logic reg_read, reg_write, reg_addrvalid;
  logic [7:0] reg_datai;
  int errors = 0;
  int checks = 0;
`ifdef REG_ARB_BURST_EN
  localparam int NRD = 3;
  localparam int NWR = 5;
`else
  localparam int NRD = 1;
  localparam int NWR = 1;
`endif
  always #5 cwusb_clk = ~cwusb_clk;
  assign reg_datai = 8'h10 + 8'(reg_bytecnt);
  usb_reg_arbiter dut (
    .cwusb_clk(cwusb_clk), .reset_n(reset_n),
    .host_address(host_address), .host_bytecnt(host_bytecnt), .host_datao(host_datao),
    .host_read(host_read), .host_write(host_write), .host_addrvalid(host_addrvalid),
    .host_datai(host_datai),
    .lcl_req(lcl_req), .lcl_wr(lcl_wr), .lcl_address(lcl_address), .lcl_len(lcl_len),
    .lcl_wdata(lcl_wdata), .lcl_wready(lcl_wready), .lcl_rdata(lcl_rdata),
    .lcl_rvalid(lcl_rvalid), .lcl_done(lcl_done), .lcl_abort(lcl_abort), .lcl_busy(lcl_busy),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datao(reg_datao),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
    .reg_datai(reg_datai)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge cwusb_clk);
    #1;
  endtask
  initial begin
    int nw, lastbc;
    logic seen;
    #1 reset_n = 1'b0;
    host_address = 6'h2A; host_bytecnt = 7'h33; host_datao = 8'h5C; host_read = 1'b1; host_addrvalid = 1'b1;
    #2;
    check("rst_busy", lcl_busy, 0);
    check("rst_done", lcl_done, 0);
    check("rst_abort", lcl_abort, 0);
    check("rst_rvalid", lcl_rvalid, 0);
    check("rst_rdata", lcl_rdata, 0);
    check("rst_wready", lcl_wready, 0);
    check("rst_mirror_addr", reg_address, 6'h2A);
    check("rst_mirror_cnt", reg_bytecnt, 7'h33);
    check("rst_mirror_rd", reg_read, 1);
    @(negedge cwusb_clk) reset_n = 1'b1;
    tick;
    host_read = 1'b0; host_write = 1'b1; host_datao = 8'h77; host_address = 6'h11;
    #1;
    check("host_wr_mirror", reg_write, 1);
    check("host_datao_mirror", reg_datao, 8'h77);
    check("host_addr_mirror", reg_address, 6'h11);
    check("host_datai", host_datai, 8'h10 + 8'h33);
    check("host_no_wready", lcl_wready, 0);
    lcl_req = 1'b1; lcl_wr = 1'b1; lcl_address = 6'h12; lcl_wdata = 8'hA5; lcl_len = 7'd1;
    tick;
    host_write = 1'b0; host_addrvalid = 1'b0; host_address = '0; host_bytecnt = '0; host_datao = '0;
    repeat (4) tick;
    check("gap_not_met", lcl_busy, 0);
    tick;
    check("wr_addr_busy", lcl_busy, 1);
    check("wr_addr_av", reg_addrvalid, 1);
    check("wr_addr_addr", reg_address, 6'h12);
    check("wr_addr_nowr", reg_write, 0);
    tick;
    check("wr_xfer_wr", reg_write, 1);
    check("wr_xfer_data", reg_datao, 8'hA5);
    check("wr_xfer_wready", lcl_wready, 1);
    check("wr_xfer_cnt", reg_bytecnt, 0);
    tick;
    check("wr_wait_wr", reg_write, 0);
    check("wr_wait_av", reg_addrvalid, 1);
    check("wr_wait_done", lcl_done, 0);
    tick;
    check("wr_done", lcl_done, 1);
    check("wr_done_av", reg_addrvalid, 0);
    lcl_req = 1'b0;
    tick;
    check("wr_idle_done", lcl_done, 0);
    check("wr_idle_busy", lcl_busy, 0);
    lcl_req = 1'b1; lcl_wr = 1'b1; lcl_address = 6'h21; lcl_wdata = 8'h3C;
    tick;
    check("pre_addr_busy", lcl_busy, 1);
    tick;
    host_addrvalid = 1'b1; host_address = 6'h07;
    #1;
    check("pre_no_wr", reg_write, 0);
    check("pre_host_addr", reg_address, 6'h07);
    check("pre_no_wready", lcl_wready, 0);
    check("pre_no_abort_yet", lcl_abort, 0);
    tick;
    check("pre_abort", lcl_abort, 1);
    check("pre_idle", lcl_busy, 0);
    host_addrvalid = 1'b0; host_address = '0; lcl_req = 1'b0;
    tick;
    check("pre_abort_pulse", lcl_abort, 0);
    lcl_req = 1'b1; lcl_wr = 1'b0; lcl_address = 6'h05; lcl_len = 7'd3;
    for (int i = 0; i < 9; i++) begin
      host_read = (i % 3 == 0);
      tick;
      check("dly_no_grant", lcl_busy, 0);
    end
    host_read = 1'b0;
    tick;
    check("dly_cnt3", lcl_busy, 0);
    tick;
    check("dly_cnt4", lcl_busy, 0);
    tick;
    check("rd_addr_busy", lcl_busy, 1);
    check("rd_addr_addr", reg_address, 6'h05);
    check("rd_addr_nord", reg_read, 0);
    tick;
    for (int b = 0; b < NRD; b++) begin
      check("rd_xfer_rd", reg_read, 1);
      check("rd_xfer_cnt", reg_bytecnt, b);
      tick;
      check("rd_wait_rd", reg_read, 0);
      check("rd_wait_rvalid", lcl_rvalid, 0);
      tick;
      check("rd_rvalid", lcl_rvalid, 1);
      check("rd_rdata", lcl_rdata, 8'h10 + 8'(b));
    end
    check("rd_done", lcl_done, 1);
    lcl_req = 1'b0;
    tick;
    check("rd_done_pulse", lcl_done, 0);
    check("rd_rvalid_pulse", lcl_rvalid, 0);
    lcl_req = 1'b1; lcl_wr = 1'b1; lcl_address = 6'h30; lcl_wdata = 8'h11; lcl_len = 7'd5;
    nw = 0; lastbc = -1; seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (reg_write) begin
        nw++;
        lastbc = int'(reg_bytecnt);
      end
      if (lcl_done) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    lcl_req = 1'b0;
    check("len5_done_seen", seen, 1);
    check("len5_nwrites", nw, NWR);
    check("len5_last_cnt", lastbc, NWR - 1);
    tick;
    lcl_req = 1'b1; lcl_address = 6'h12; lcl_wdata = 8'h5A; lcl_len = 7'd1;
    tick;
    tick;
    check("mr_xfer_wr", reg_write, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mr_no_wr", reg_write, 0);
    check("mr_no_busy", lcl_busy, 0);
    check("mr_no_wready", lcl_wready, 0);
    check("mr_no_av", reg_addrvalid, 0);
    lcl_req = 1'b0;
    @(negedge cwusb_clk) reset_n = 1'b1;
    tick;
    check("mr_idle", lcl_busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
